// File: rtl/iram_mon_ctrl.sv
// rtl/iram_mon_ctrl.sv - monitor-side IRAM write/read sequencer and CPU run/stop control
module iram_mon_ctrl #(
    parameter int IWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [29:0]       cmd_adr,
    input  logic [31:0]       cmd_data,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [IWIDTH-1:0] i_ram_radr,
    input  logic [31:0]       i_ram_rdata,
    output logic              i_read_sel,
    output logic [IWIDTH-1:0] i_ram_wadr,
    output logic [31:0]       i_ram_wdata,
    output logic              i_ram_wen,
    output logic              cpu_start,
    output logic [29:0]       start_adr,
    output logic              cpu_halt,
    output logic              cpu_running
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ADR,
        S_RD_DATA,
        S_START,
        S_RSP
    } state_t;

    localparam logic [2:0] OP_WRITE      = 3'd0;
    localparam logic [2:0] OP_WRITE_NEXT = 3'd1;
    localparam logic [2:0] OP_READ       = 3'd2;
    localparam logic [2:0] OP_READ_NEXT  = 3'd3;
    localparam logic [2:0] OP_RUN        = 3'd4;
    localparam logic [2:0] OP_STOP       = 3'd5;

    state_t              state_q, state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [IWIDTH-1:0]   radr_q, radr_d;
    logic                read_sel_q, read_sel_d;
    logic [IWIDTH-1:0]   wadr_q, wadr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                wen_q, wen_d;
    logic                cpu_start_q, cpu_start_d;
    logic [29:0]         start_adr_q, start_adr_d;
    logic                cpu_halt_q, cpu_halt_d;
    logic                cpu_running_q, cpu_running_d;
    logic [IWIDTH-1:0]   auto_adr_q, auto_adr_d;

    logic                is_ram_op;
    logic                is_next_op;
    logic                adr_out_of_range;
    logic                cmd_err;
    logic [IWIDTH-1:0]   ram_adr;

    // Address-range check only applies to the explicit-address ops; *_NEXT uses auto_adr.
    always_comb begin
        is_ram_op        = (cmd_op <= OP_READ_NEXT);
        is_next_op       = (cmd_op == OP_WRITE_NEXT) || (cmd_op == OP_READ_NEXT);
        adr_out_of_range = ((cmd_op == OP_WRITE) || (cmd_op == OP_READ)) && (|cmd_adr[29:IWIDTH]);
        cmd_err          = (cmd_op > OP_STOP) || (is_ram_op && cpu_running_q) || adr_out_of_range;
        ram_adr          = is_next_op ? auto_adr_q : cmd_adr[IWIDTH-1:0];
    end

    always_comb begin
        state_d       = state_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = 32'd0;
        rsp_err_d     = 1'b0;
        radr_d        = radr_q;
        read_sel_d    = 1'b0;
        wadr_d        = wadr_q;
        wdata_d       = wdata_q;
        wen_d         = 1'b0;
        cpu_start_d   = 1'b0;
        start_adr_d   = start_adr_q;
        cpu_halt_d    = cpu_halt_q;
        cpu_running_d = cpu_running_q;
        auto_adr_d    = auto_adr_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_err) begin
                        state_d     = S_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        unique case (cmd_op)
                            OP_WRITE, OP_WRITE_NEXT: begin
                                state_d    = S_WR;
                                wen_d      = 1'b1;
                                wadr_d     = ram_adr;
                                wdata_d    = cmd_data;
                                auto_adr_d = ram_adr + IWIDTH'(1);
                            end
                            OP_READ, OP_READ_NEXT: begin
                                state_d    = S_RD_ADR;
                                read_sel_d = 1'b1;
                                radr_d     = ram_adr;
                                auto_adr_d = ram_adr + IWIDTH'(1);
                            end
                            OP_RUN: begin
                                state_d       = S_START;
                                cpu_start_d   = 1'b1;
                                start_adr_d   = cmd_adr;
                                cpu_halt_d    = 1'b0;
                                cpu_running_d = 1'b1;
                            end
                            default: begin
                                state_d       = S_RSP;
                                rsp_valid_d   = 1'b1;
                                cpu_halt_d    = 1'b1;
                                cpu_running_d = 1'b0;
                            end
                        endcase
                    end
                end
            end
            S_WR: begin
                state_d     = S_RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = wdata_q;
            end
            S_RD_ADR: begin
                state_d    = S_RD_DATA;
                read_sel_d = 1'b1;
            end
            S_RD_DATA: begin
                state_d     = S_RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = i_ram_rdata;
            end
            S_START: begin
                state_d     = S_RSP;
                rsp_valid_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    // Async reset drops wen/read_sel at once so an interrupted access never completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= 32'd0;
            rsp_err_q     <= 1'b0;
            radr_q        <= '0;
            read_sel_q    <= 1'b0;
            wadr_q        <= '0;
            wdata_q       <= 32'd0;
            wen_q         <= 1'b0;
            cpu_start_q   <= 1'b0;
            start_adr_q   <= 30'd0;
            cpu_halt_q    <= 1'b1;
            cpu_running_q <= 1'b0;
            auto_adr_q    <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            radr_q        <= radr_d;
            read_sel_q    <= read_sel_d;
            wadr_q        <= wadr_d;
            wdata_q       <= wdata_d;
            wen_q         <= wen_d;
            cpu_start_q   <= cpu_start_d;
            start_adr_q   <= start_adr_d;
            cpu_halt_q    <= cpu_halt_d;
            cpu_running_q <= cpu_running_d;
            auto_adr_q    <= auto_adr_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign i_ram_radr  = radr_q;
    assign i_read_sel  = read_sel_q;
    assign i_ram_wadr  = wadr_q;
    assign i_ram_wdata = wdata_q;
    assign i_ram_wen   = wen_q;
    assign cpu_start   = cpu_start_q;
    assign start_adr   = start_adr_q;
    assign cpu_halt    = cpu_halt_q;
    assign cpu_running = cpu_running_q;

endmodule

// File: doc/iram_mon_ctrl.md
Name: iram_mon_ctrl

Overview:
- Monitor-side sequencer for the instruction RAM write port and the monitor read path of the fetch stage.
- Accepts word-level commands from the debug monitor (UART command decoder): write, read, run and stop.
- Drives i_ram_wen/i_ram_wadr/i_ram_wdata, i_read_sel/i_ram_radr, cpu_start/start_adr and the CPU halt level.
- Enforces one rule: IRAM is touched only while the CPU is stopped.

Parameters:
IWIDTH, 12, IRAM word-address width; IRAM holds 2^IWIDTH 32-bit words.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command strobe from monitor
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready
cmd_op  in  3  0 WRITE, 1 WRITE_NEXT, 2 READ, 3 READ_NEXT, 4 RUN, 5 STOP, 6/7 illegal
cmd_adr  in  30  word address [31:2] for WRITE/READ/RUN
cmd_data  in  32  write data
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  32  read data, write echo, else 0
rsp_err  out  1  error flag, valid with rsp_valid
i_ram_radr  out  IWIDTH  monitor read address
i_ram_rdata  in  32  IRAM read data, valid one cycle after i_ram_radr
i_read_sel  out  1  steers IRAM read port to monitor
i_ram_wadr  out  IWIDTH  IRAM write address
i_ram_wdata  out  32  IRAM write data
i_ram_wen  out  1  IRAM write enable
cpu_start  out  1  one-cycle start pulse
start_adr  out  30  start PC [31:2]
cpu_halt  out  1  level; CPU pipeline held while high
cpu_running  out  1  status

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- All outputs are registered. Reset values: every output 0 except cmd_ready=1 and cpu_halt=1. State IDLE, auto_adr=0.
- Asserting rst_n low mid-operation clears i_ram_wen and i_read_sel immediately. No partial write completes. The command is lost and no response is issued.
- States: IDLE, WR, RD_ADR, RD_DATA, START, RSP. Accept cycle is T. Exactly one command is in flight.
- Error check runs at T; on error the FSM goes IDLE->RSP. The response is at T+1 with rsp_err=1 and rsp_data=0. No RAM, start or auto_adr side effect. Error causes:
  - op 6/7;
  - WRITE/WRITE_NEXT/READ/READ_NEXT while cpu_running=1;
  - WRITE/READ with cmd_adr[31:IWIDTH+2] != 0.
- WRITE / WRITE_NEXT:
  - T+1 WR: i_ram_wen=1 for exactly one cycle, i_ram_wadr = cmd_adr[IWIDTH+1:2] (or auto_adr), i_ram_wdata = cmd_data.
  - T+2 RSP: rsp_data = written data.
- READ / READ_NEXT:
  - T+1 RD_ADR: i_read_sel=1, i_ram_radr = address.
  - T+2 RD_DATA: i_read_sel stays 1; i_ram_rdata captured.
  - T+3 RSP: i_read_sel=0, rsp_data = captured word.
- auto_adr update: on successful WRITE/READ, auto_adr = address+1; on *_NEXT, auto_adr increments. Wraps modulo 2^IWIDTH with no error.
- RUN:
  - T+1 START: start_adr = cmd_adr (any 30-bit value), cpu_start=1 for one cycle, cpu_halt=0, cpu_running=1.
  - T+2 RSP, rsp_data=0.
  - RUN while already running is legal: it restarts at the new address.
- STOP:
  - T+1 RSP: cpu_halt=1, cpu_running=0 take effect in the same cycle.
  - STOP while stopped is legal and has no effect.
- RSP lasts exactly one cycle, then IDLE; the next accept is possible at the following cycle.
- cmd_valid outside IDLE is ignored. The monitor holds it until it sees cmd_ready.
- i_ram_wen and i_read_sel are never high together.

Test Plan:
- After reset: cmd_ready=1, cpu_halt=1, others 0. WRITE adr 0x005, data 0xDEADBEEF -> i_ram_wen at T+1 (wadr 5), rsp_valid at T+2 with data 0xDEADBEEF, err 0.
- WRITE adr 0xFFF, data 0x11, then WRITE_NEXT data 0x22 -> second write lands at wadr 0x000 (wrap). READ adr 0xFFF, READ_NEXT -> rsp_data 0x11 at T+3, then 0x22. i_read_sel high exactly 2 cycles each.
- RUN adr 0x00000040 -> cpu_start one-cycle pulse with start_adr 0x40 at T+1, cpu_running=1, cpu_halt=0. A subsequent WRITE -> rsp_err=1 at T+1, no i_ram_wen.
- STOP -> cpu_halt=1 at T+1. READ adr 0x1000 (IWIDTH=12) -> err. cmd_op 7 -> err with rsp_data 0. auto_adr unchanged, confirmed by READ_NEXT.
- rst_n low during WR and during RD_DATA -> i_ram_wen and i_read_sel drop immediately, no rsp_valid, and after release the FSM is in IDLE with auto_adr=0.
